// File: rtl/am_deskew_ctrl_rx.sv
// am_deskew_ctrl_rx
// Receive-side deskew and alignment controller. It sits after the per-lane
// alignment-marker (AM) lock blocks and does the following:
//   - waits until every physical lane reports AM lock;
//   - checks that the reported logical lane ids form a permutation;
//   - holds each lane's elastic buffer from its marker until every lane has
//     seen its marker, then releases all lanes on the same edge;
//   - keeps watching AM rounds while aligned, and drops alignment after
//     BAD_AM_N consecutive bad rounds.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   valid_i     common block-valid strobe; windows and masks advance only on it
//   lock_v_i    per physical lane AM lock status
//   am_v_i      per physical lane AM-received pulse (qualified by valid_i)
//   lane_i      per physical lane logical id, slice p = [p*LANE_W +: LANE_W]
//   hold_o      per physical lane buffer hold (1 = stop reading)
//   align_v_o   lanes locked, mapped and deskewed
//   lane_sel_o  slice l = physical lane that carries logical lane l
//   skew_err_o  one-cycle pulse: skew window exceeded or duplicate AM
//   map_err_o   one-cycle pulse: logical lane ids are not a permutation
module am_deskew_ctrl_rx #(
    parameter int LANE_N   = 4,
    parameter int LANE_W   = $clog2(LANE_N),
    parameter int MAX_SKEW = 16,
    parameter int SKEW_W   = $clog2(MAX_SKEW + 1),
    parameter int BAD_AM_N = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [LANE_N-1:0]        lock_v_i,
    input  logic [LANE_N-1:0]        am_v_i,
    input  logic [LANE_N*LANE_W-1:0] lane_i,
    output logic [LANE_N-1:0]        hold_o,
    output logic                     align_v_o,
    output logic [LANE_N*LANE_W-1:0] lane_sel_o,
    output logic                     skew_err_o,
    output logic                     map_err_o
);

    localparam int                BAD_W     = $clog2(BAD_AM_N + 1);
    localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(MAX_SKEW);
    localparam logic [BAD_W-1:0]  BAD_LIMIT = BAD_W'(BAD_AM_N);

    typedef enum logic [2:0] {
        LOCK_WAIT,
        MAP_CHECK,
        AM_WAIT,
        SKEW_CNT,
        ALIGNED
    } state_t;

    state_t                   state;
    logic [LANE_N-1:0]        seen;      // lanes whose AM arrived in the open round
    logic [SKEW_W-1:0]        skew_cnt;  // valid cycles since the round's first AM
    logic [BAD_W-1:0]         bad_cnt;   // consecutive bad rounds while aligned
    logic [LANE_N*LANE_W-1:0] lane_map;  // lane_i as accepted by MAP_CHECK

    logic                     map_ok;
    logic [LANE_N*LANE_W-1:0] sel_next;
    logic                     drop;
    logic                     seen_full;
    logic                     dup_am;
    logic                     expire;
    logic [BAD_W-1:0]         bad_next;

    // Inverse map: for every logical id, find the single physical lane that
    // reports it. Exactly one hit per logical id means lane_i is a
    // permutation, which covers both duplicates and out-of-range ids.
    always_comb begin
        int hits;
        // NOTE: every signal driven here gets a default before any branch,
        // so no path leaves a value to be remembered and no latch is inferred.
        map_ok   = 1'b1;
        sel_next = '0;
        hits     = 0;
        for (int l = 0; l < LANE_N; l++) begin
            hits = 0;
            for (int p = 0; p < LANE_N; p++) begin
                if (lane_i[p*LANE_W +: LANE_W] == LANE_W'(l)) begin
                    hits++;
                    sel_next[l*LANE_W +: LANE_W] = LANE_W'(p);
                end
            end
            if (hits != 1) map_ok = 1'b0;
        end
    end

    // Lock loss anywhere past LOCK_WAIT, or a lane id change while aligned,
    // restarts the whole bring-up and overrides every other transition.
    assign drop      = ((state != LOCK_WAIT) && !(&lock_v_i)) ||
                       ((state == ALIGNED) && (lane_i != lane_map));
    assign seen_full = &seen;
    assign dup_am    = |(seen & am_v_i);
    // The count would step past MAX_SKEW on this valid cycle.
    assign expire    = (skew_cnt == SKEW_LAST);
    assign bad_next  = (bad_cnt == BAD_LIMIT) ? bad_cnt : bad_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOCK_WAIT;
            seen       <= '0;
            skew_cnt   <= '0;
            bad_cnt    <= '0;
            lane_map   <= '0;
            hold_o     <= '0;
            align_v_o  <= 1'b0;
            skew_err_o <= 1'b0;
            map_err_o  <= 1'b0;
            for (int l = 0; l < LANE_N; l++)
                lane_sel_o[l*LANE_W +: LANE_W] <= LANE_W'(l);
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the statement order.
            skew_err_o <= 1'b0;
            map_err_o  <= 1'b0;

            if (drop) begin
                state     <= LOCK_WAIT;
                hold_o    <= '0;
                align_v_o <= 1'b0;
                seen      <= '0;
                skew_cnt  <= '0;
                bad_cnt   <= '0;
            end else begin
                case (state)
                    LOCK_WAIT: begin
                        if (&lock_v_i) state <= MAP_CHECK;
                    end

                    MAP_CHECK: begin
                        if (map_ok) begin
                            lane_sel_o <= sel_next;
                            lane_map   <= lane_i;
                            state      <= AM_WAIT;
                        end else begin
                            map_err_o <= 1'b1;
                            state     <= LOCK_WAIT;
                        end
                    end

                    AM_WAIT: begin
                        if (valid_i && (am_v_i != '0)) begin
                            seen     <= am_v_i;
                            skew_cnt <= '0;
                            // All markers together: nothing to deskew, so
                            // no lane is held; SKEW_CNT releases next valid cycle.
                            hold_o   <= (&am_v_i) ? '0 : am_v_i;
                            state    <= SKEW_CNT;
                        end
                    end

                    SKEW_CNT: begin
                        if (valid_i) begin
                            // Completion is tested first so it wins over a
                            // coincident expiry.
                            if (seen_full) begin
                                hold_o    <= '0;
                                align_v_o <= 1'b1;
                                bad_cnt   <= '0;
                                seen      <= '0;
                                skew_cnt  <= '0;
                                state     <= ALIGNED;
                            end else if (dup_am || expire) begin
                                skew_err_o <= 1'b1;
                                hold_o     <= '0;
                                seen       <= '0;
                                skew_cnt   <= '0;
                                state      <= AM_WAIT;
                            end else begin
                                skew_cnt <= skew_cnt + 1'b1;
                                seen     <= seen | am_v_i;
                                hold_o   <= hold_o | am_v_i;
                            end
                        end
                    end

                    ALIGNED: begin
                        // Same window as SKEW_CNT, but buffers stay released.
                        // An empty seen mask means no round is open.
                        if (valid_i) begin
                            if (seen == '0) begin
                                if (am_v_i != '0) begin
                                    seen     <= am_v_i;
                                    skew_cnt <= '0;
                                end
                            end else if (seen_full) begin
                                bad_cnt  <= '0;
                                seen     <= '0;
                                skew_cnt <= '0;
                            end else if (dup_am || expire) begin
                                skew_err_o <= 1'b1;
                                seen       <= '0;
                                skew_cnt   <= '0;
                                bad_cnt    <= bad_next;
                                if (bad_next == BAD_LIMIT) begin
                                    align_v_o <= 1'b0;
                                    state     <= AM_WAIT;
                                end
                            end else begin
                                skew_cnt <= skew_cnt + 1'b1;
                                seen     <= seen | am_v_i;
                            end
                        end
                    end

                    default: state <= LOCK_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_am_deskew_ctrl_rx.sv
// Self-checking bench for am_deskew_ctrl_rx: directed scenarios followed by
// randomized AM rounds, lock drops and lane remaps, compared every cycle
// against a timestamp-based reference model of the alignment rules.
module tb_am_deskew_ctrl_rx;

    localparam int LANE_N   = 4;
    localparam int LANE_W   = 2;
    localparam int MAX_SKEW = 16;
    localparam int BAD_AM_N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [3:0] lock_v_i;
    logic [3:0] am_v_i;
    logic [7:0] lane_i;
    logic [3:0] hold_o;
    logic       align_v_o;
    logic [7:0] lane_sel_o;
    logic       skew_err_o;
    logic       map_err_o;

    am_deskew_ctrl_rx #(
        .LANE_N  (LANE_N),
        .LANE_W  (LANE_W),
        .MAX_SKEW(MAX_SKEW),
        .BAD_AM_N(BAD_AM_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .lock_v_i  (lock_v_i),
        .am_v_i    (am_v_i),
        .lane_i    (lane_i),
        .hold_o    (hold_o),
        .align_v_o (align_v_o),
        .lane_sel_o(lane_sel_o),
        .skew_err_o(skew_err_o),
        .map_err_o (map_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Bring-up is seen as four phases; acquisition and monitoring share one
    // notion of an AM round: the valid-cycle index of its first marker plus
    // the set of lanes that have arrived since.
    typedef enum int {M_DOWN, M_MAPPING, M_ACQUIRE, M_LOCKED} mphase_t;

    mphase_t    ph;
    longint     vc;        // number of valid cycles seen so far
    longint     first;     // vc of the round's first AM, -1 if no round open
    logic [3:0] arrived;
    int         m_bad;
    logic [7:0] m_lanes;
    logic [3:0] exp_hold;
    logic       exp_align;
    logic [7:0] exp_sel;
    logic       exp_skew;
    logic       exp_map;

    function automatic void model_reset();
        ph        = M_DOWN;
        vc        = 0;
        first     = -1;
        arrived   = '0;
        m_bad     = 0;
        m_lanes   = '0;
        exp_hold  = '0;
        exp_align = 1'b0;
        exp_sel   = 8'hE4;  // identity: logical l on physical l
        exp_skew  = 1'b0;
        exp_map   = 1'b0;
    endfunction

    function automatic void track_round();
        if (first < 0) begin
            if (am_v_i != 4'h0) begin
                first   = vc;
                arrived = am_v_i;
                if (ph == M_ACQUIRE) exp_hold = (am_v_i == 4'hF) ? 4'h0 : am_v_i;
            end
        end else if (arrived == 4'hF) begin
            first   = -1;
            arrived = '0;
            m_bad   = 0;
            if (ph == M_ACQUIRE) begin
                exp_hold  = '0;
                exp_align = 1'b1;
                ph        = M_LOCKED;
            end
        end else if (((am_v_i & arrived) != 4'h0) || (vc - first > MAX_SKEW)) begin
            exp_skew = 1'b1;
            first    = -1;
            arrived  = '0;
            if (ph == M_ACQUIRE) begin
                exp_hold = '0;
            end else begin
                if (m_bad < BAD_AM_N) m_bad++;
                if (m_bad >= BAD_AM_N) begin
                    exp_align = 1'b0;
                    ph        = M_ACQUIRE;
                end
            end
        end else begin
            arrived = arrived | am_v_i;
            if (ph == M_ACQUIRE) exp_hold = exp_hold | am_v_i;
        end
    endfunction

    function automatic void model_step();
        exp_skew = 1'b0;
        exp_map  = 1'b0;
        if ((ph != M_DOWN && lock_v_i != 4'hF) || (ph == M_LOCKED && lane_i != m_lanes)) begin
            ph        = M_DOWN;
            exp_hold  = '0;
            exp_align = 1'b0;
            first     = -1;
            arrived   = '0;
            m_bad     = 0;
        end else begin
            case (ph)
                M_DOWN: if (lock_v_i == 4'hF) ph = M_MAPPING;
                M_MAPPING: begin
                    int owner[4];
                    bit ok;
                    int id;
                    ok = 1'b1;
                    for (int l = 0; l < 4; l++) owner[l] = -1;
                    for (int p = 0; p < 4; p++) begin
                        id = int'(lane_i[p*2 +: 2]);
                        if (owner[id] != -1) ok = 1'b0;
                        owner[id] = p;
                    end
                    if (ok) begin
                        for (int l = 0; l < 4; l++) exp_sel[l*2 +: 2] = 2'(owner[l]);
                        m_lanes = lane_i;
                        first   = -1;
                        arrived = '0;
                        ph      = M_ACQUIRE;
                    end else begin
                        exp_map = 1'b1;
                        ph      = M_DOWN;
                    end
                end
                default: begin
                    if (valid_i) begin
                        track_round();
                        vc++;
                    end
                end
            endcase
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/hold"},     32'(hold_o),     32'(exp_hold));
        check({tag, "/align"},    32'(align_v_o),  32'(exp_align));
        check({tag, "/sel"},      32'(lane_sel_o), 32'(exp_sel));
        check({tag, "/skew_err"}, 32'(skew_err_o), 32'(exp_skew));
        check({tag, "/map_err"},  32'(map_err_o),  32'(exp_map));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic bad_round(input string tag);
        am_v_i = 4'b1011;  // lane 2 silent
        tick(tag);
        am_v_i = 4'h0;
        repeat (17) tick(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         rel;
        int         off[4];
        logic [1:0] perm[4];
        logic [1:0] tmp;
        int         j;

        reset    = 1'b1;
        valid_i  = 1'b1;
        lock_v_i = 4'h0;
        am_v_i   = 4'h0;
        lane_i   = 8'hE4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset/sel_identity", 32'(lane_sel_o), 32'h0E4);
        reset = 1'b0;

        // 1: identity map, all markers in one cycle
        lock_v_i = 4'hF;
        tick("t1_lock");
        tick("t1_map");
        am_v_i = 4'hF;
        tick("t1_am");
        check("t1/hold_never", 32'(hold_o), 32'h0);
        check("t1/align_not_yet", 32'(align_v_o), 32'h0);
        am_v_i = 4'h0;
        tick("t1_rel");
        check("t1/align", 32'(align_v_o), 32'h1);
        check("t1/sel", 32'(lane_sel_o), 32'h0E4);

        // 2: permuted map, staggered markers with invalid gaps
        lock_v_i = 4'b1101;
        tick("t2_drop");
        check("t2/align_drop", 32'(align_v_o), 32'h0);
        lock_v_i = 4'hF;
        lane_i   = 8'h72;  // phys0..3 carry logical 2,0,3,1
        tick("t2_lock");
        tick("t2_map");
        check("t2/sel", 32'(lane_sel_o), 32'h08D);  // logical0..3 on phys 1,3,0,2
        for (int c = 0; c < 10; c++) begin
            am_v_i = (c == 0) ? 4'h1 : (c == 3) ? 4'h2 : (c == 5) ? 4'h4 : (c == 9) ? 4'h8 : 4'h0;
            tick("t2_stagger");
            if (c == 0) check("t2/hold0", 32'(hold_o), 32'h1);
            if (c == 3) check("t2/hold3", 32'(hold_o), 32'h3);
            if (c == 5) check("t2/hold5", 32'(hold_o), 32'h7);
            if (c == 9) check("t2/hold9", 32'(hold_o), 32'hF);
            if (c == 3) begin
                valid_i = 1'b0;
                am_v_i  = 4'h4;  // ignored: not a valid cycle
                repeat (2) tick("t2_gap");
                check("t2/hold_gap", 32'(hold_o), 32'h3);
                valid_i = 1'b1;
            end
        end
        am_v_i = 4'h0;
        tick("t2_rel");
        check("t2/hold_rel", 32'(hold_o), 32'h0);
        check("t2/align", 32'(align_v_o), 32'h1);

        // 3: lane 3 silent, window expires on the 17th valid cycle
        lock_v_i = 4'b0111;
        tick("t3_drop");
        lock_v_i = 4'hF;
        tick("t3_lock");
        tick("t3_map");
        am_v_i = 4'h7;
        tick("t3_am");
        am_v_i = 4'h0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 8) begin
                valid_i = 1'b0;
                tick("t3_gap");
                valid_i = 1'b1;
            end
            tick("t3_wait");
            if (c == 16) check("t3/no_err_16", 32'(skew_err_o), 32'h0);
            if (c == 17) begin
                check("t3/err_17", 32'(skew_err_o), 32'h1);
                check("t3/hold", 32'(hold_o), 32'h0);
                check("t3/align", 32'(align_v_o), 32'h0);
            end
        end
        tick("t3_after");
        check("t3/pulse_once", 32'(skew_err_o), 32'h0);

        // 4: duplicate logical id
        lock_v_i = 4'b1110;
        tick("t4_drop");
        lock_v_i = 4'hF;
        lane_i   = 8'hE5;  // phys0 and phys1 both claim logical 1
        tick("t4_lock");
        tick("t4_map");
        check("t4/map_err", 32'(map_err_o), 32'h1);
        tick("t4_relock");
        check("t4/map_err_low", 32'(map_err_o), 32'h0);
        tick("t4_remap");
        check("t4/map_err_again", 32'(map_err_o), 32'h1);
        check("t4/align", 32'(align_v_o), 32'h0);
        lane_i = 8'h72;
        tick("t4_lock2");
        tick("t4_map2");
        check("t4/map_ok", 32'(map_err_o), 32'h0);

        // 5: bad rounds while aligned, one good round in between
        am_v_i = 4'hF;
        tick("t5_am");
        am_v_i = 4'h0;
        tick("t5_rel");
        check("t5/aligned", 32'(align_v_o), 32'h1);
        bad_round("t5_bad1");
        check("t5/err1", 32'(skew_err_o), 32'h1);
        bad_round("t5_bad2");
        check("t5/align2", 32'(align_v_o), 32'h1);
        am_v_i = 4'hF;
        tick("t5_good");
        am_v_i = 4'h0;
        tick("t5_good_end");
        bad_round("t5_bad3");
        bad_round("t5_bad4");
        check("t5/align_after_reset_cnt", 32'(align_v_o), 32'h1);
        bad_round("t5_bad5");
        check("t5/err5", 32'(skew_err_o), 32'h1);
        check("t5/align_lost", 32'(align_v_o), 32'h0);

        // 6: lock loss from ALIGNED, then reset in the middle of a window
        am_v_i = 4'hF;
        tick("t6_am");
        am_v_i = 4'h0;
        tick("t6_rel");
        check("t6/aligned", 32'(align_v_o), 32'h1);
        lock_v_i = 4'b1101;
        tick("t6_drop");
        check("t6/align_drop", 32'(align_v_o), 32'h0);
        lock_v_i = 4'hF;
        tick("t6_lock");
        tick("t6_map");
        am_v_i = 4'h1;
        tick("t6_am1");
        am_v_i = 4'h2;
        tick("t6_am2");
        check("t6/hold_built", 32'(hold_o), 32'h3);
        am_v_i = 4'h0;
        #2;
        reset = 1'b1;
        #1;
        check("t6/async_hold", 32'(hold_o), 32'h0);
        check("t6/async_align", 32'(align_v_o), 32'h0);
        check("t6/async_sel", 32'(lane_sel_o), 32'h0E4);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized rounds, lock drops and remaps
        rel      = -1;
        lane_i   = 8'h72;
        lock_v_i = 4'hF;
        for (int k = 0; k < 4; k++) off[k] = -1;
        for (int i = 0; i < 4000; i++) begin
            lock_v_i = ($urandom_range(0, 299) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 399) == 0) begin
                for (int k = 0; k < 4; k++) perm[k] = 2'(k);
                for (int k = 3; k > 0; k--) begin
                    j       = $urandom_range(0, k);
                    tmp     = perm[k];
                    perm[k] = perm[j];
                    perm[j] = tmp;
                end
                for (int k = 0; k < 4; k++) lane_i[k*2 +: 2] = perm[k];
            end
            if ($urandom_range(0, 999) == 0) lane_i = 8'($urandom);
            valid_i = ($urandom_range(0, 3) != 0);
            am_v_i  = 4'h0;
            if (valid_i) begin
                if (rel < 0 && $urandom_range(0, 19) == 0) begin
                    rel = 0;
                    for (int k = 0; k < 4; k++)
                        off[k] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 18));
                end
                if (rel >= 0) begin
                    for (int k = 0; k < 4; k++) am_v_i[k] = (off[k] == rel);
                    rel++;
                    if (rel > 24) rel = -1;
                end
                if ($urandom_range(0, 63) == 0) am_v_i[$urandom_range(0, 3)] = 1'b1;
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
